e_mdu_ctrl: RTL and testbench
=============================

// Module: e_mdu_ctrl
// PURPOSE
//  Execute-stage multiply/divide unit controller for the 5-stage MIPS pipeline.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E. Sequences the multi-cycle
//  busy window and commits HI/LO. Raises a stall request to the hazard unit while any
//  D-stage MDU instruction would collide with an operation in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1, >=MULT_CYCLES)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  MDUOp     in   4   E-stage op code (package encodings; MDU_NONE = 0)
//  start     in   1   E-stage op valid this cycle (qualifies MDUOp)
//  rs_val    in   32  forwarded rs operand (E)
//  rt_val    in   32  forwarded rt operand (E)
//  D_is_md   in   1   D-stage instruction is any MDU op
//  busy      out  1   multi-cycle op in flight
//  stall     out  1   stall request to D: D_is_md & (busy | E-stage mult/div start)
//  HI        out  32  architectural HI
//  LO        out  32  architectural LO
//  MDU_out   out  32  MFHI -> HI, MFLO -> LO, else 0 (combinational from regs)
// BEHAVIOUR
//  - Reset: busy=0, counter=0, HI=0, LO=0, result shadows=0. Reset wins over start.
//    Reset mid-operation aborts it; HI/LO read 0 on the next cycle.
//  - States IDLE/RUN (implied by counter!=0).
//  - IDLE + start with MULT/MULTU/DIV/DIVU at cycle t:
//    - latch result into shadow; counter <= N (MULT_CYCLES or DIV_CYCLES).
//    - busy=1 in cycles t+1..t+N.
//    - HI/LO committed at the edge ending cycle t+N; busy=0 in t+N+1.
//  - RUN: counter decrements each cycle. At counter==1, commit shadow and go IDLE.
//  - MTHI/MTLO with start in IDLE: HI<=rs_val / LO<=rs_val at the next edge; no busy.
//  - MFHI/MFLO: pure read of committed HI/LO; no state change.
//  - start while busy cannot occur legally, because stall blocks it.
//    - The RTL ignores it: no state change.
//    - The bench flags it with an assertion.
//  - Arithmetic:
//    - MULT: {HI,LO} = signed 32x32->64.
//    - MULTU: unsigned 32x32->64.
//    - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//    - DIVU: unsigned.
//    - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//    - Divide by zero: still busy DIV_CYCLES; HI/LO left unchanged at commit.
//  - stall is combinational. It covers the start cycle itself, so D is held from t
//    until busy falls, then released in t+N+1.
//  - MDUOp outside the defined set with start=1 is treated as MDU_NONE.
// STRUCTURE
//  - Shared package: MDU op encodings (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV,
//    MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO).
//  - Counter width is $clog2(DIV_CYCLES+1).
//  - One sub-module, e_mdu_calc (combinational 64-bit mult/div result from op and
//    operands). The controller owns the counter, shadows, HI/LO and stall.
// TESTING
//  1. MULT rs=0xFFFFFFFE(-2), rt=3 at t:
//     - busy t+1..t+5.
//     - HI=0xFFFFFFFF, LO=0xFFFFFFFA visible at t+6.
//  2. DIVU 7/2, then DIV 0xFFFFFFF9(-7)/2:
//     - DIVU: LO=3, HI=1.
//     - DIV: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     - Each takes 10 busy cycles.
//  3. DIV x/0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO:
//     - busy for 10 cycles.
//     - HI=0x11, LO=0x22 after.
//  4. D_is_md=1 held through a MULT:
//     - stall=1 from t through t+5, 0 at t+6.
//     - With D_is_md=0, stall stays 0 while busy.
//  5. reset asserted at t+3 of a DIV:
//     - t+4: busy=0, HI=LO=0.
//     - No later commit.
//  6. MTLO 0xDEADBEEF then MFLO next cycle:
//     - MDU_out=0xDEADBEEF.
//     - busy never asserted.

Source files
------------

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Op encodings plus the 64-bit HI/LO result bundle.
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT)  || (op == MDU_MULTU) ||
               (op == MDU_DIV)   || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage <-> MDU bundle: op issue, operands, hazard and HI/LO read-back.
// master = execute stage driver, slave = MDU controller.
interface e_mdu_ctrl_if;

    logic [3:0]  MDUOp;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        D_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    modport master (
        output MDUOp, start, rs_val, rt_val, D_is_md,
        input  busy, stall, HI, LO, MDU_out
    );

    modport slave (
        input  MDUOp, start, rs_val, rt_val, D_is_md,
        output busy, stall, HI, LO, MDU_out
    );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit multiply/divide result for the MDU controller.
// Division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN, remainder 0.
module e_mdu_calc
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output hilo_t       res_o,
    output logic        dz_o
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_u = {32'b0, a_i} * {32'b0, b_i};
    assign prod_s = $signed({{32{a_i[31]}}, a_i}) *
                    $signed({{32{b_i[31]}}, b_i});

    assign sgn   = (op_i == MDU_DIV);
    assign a_neg = sgn & a_i[31];
    assign b_neg = sgn & b_i[31];
    assign a_mag = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag = b_neg ? (32'd0 - b_i) : b_i;
    assign dz_o  = (b_i == 32'd0);

    assign q_mag = dz_o ? 32'd0 : (a_mag / b_mag);
    assign r_mag = dz_o ? 32'd0 : (a_mag % b_mag);
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_o = '0;
        unique case (1'b1)
            (op_i == MDU_MULT):  res_o = prod_s;
            (op_i == MDU_MULTU): res_o = prod_u;
            is_div(op_i):        res_o = '{hi: rem, lo: quo};
            default:             res_o = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU controller: busy window, shadow result, HI/LO commit, D stall.
// RUN is implied by a non-zero countdown; the shadow commits as it hits 1.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    e_mdu_ctrl_if.slave bus
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    hilo_t         sh_q, sh_d;
    logic          wr_q, wr_d;

    hilo_t         calc_res;
    logic          calc_dz;
    logic          busy;
    logic          md_go;

    e_mdu_calc u_calc (
        .op_i  (bus.MDUOp),
        .a_i   (bus.rs_val),
        .b_i   (bus.rt_val),
        .res_o (calc_res),
        .dz_o  (calc_dz)
    );

    assign busy  = (cnt_q != '0);
    assign md_go = bus.start & is_muldiv(bus.MDUOp);

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        sh_d  = sh_q;
        wr_d  = wr_q;
        if (busy) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1) && wr_q) begin
                hi_d = sh_q.hi;
                lo_d = sh_q.lo;
            end
        end else if (bus.start) begin
            unique case (1'b1)
                is_muldiv(bus.MDUOp): begin
                    sh_d  = calc_res;
                    // divide by zero still burns the window but never commits
                    wr_d  = !(is_div(bus.MDUOp) && calc_dz);
                    cnt_d = is_div(bus.MDUOp) ? DIV_N : MULT_N;
                end
                (bus.MDUOp == MDU_MTHI): hi_d = bus.rs_val;
                (bus.MDUOp == MDU_MTLO): lo_d = bus.rs_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            sh_q  <= '0;
            wr_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            sh_q  <= sh_d;
            wr_q  <= wr_d;
        end
    end

    assign bus.busy  = busy;
    assign bus.stall = bus.D_is_md & (busy | md_go);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    always_comb begin
        bus.MDU_out = 32'd0;
        if (bus.start) begin
            unique case (1'b1)
                (bus.MDUOp == MDU_MFHI): bus.MDU_out = hi_q;
                (bus.MDUOp == MDU_MFLO): bus.MDU_out = lo_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: arithmetic vector table plus
// hand sequences for MTHI/MTLO, divide-by-zero, stall and mid-op reset.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        logic        dmd;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    vec_t tbl[8];

    e_mdu_ctrl_if bus ();

    e_mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.start && bus.busy))
            else begin
                failures++;
                $display("FAIL start_while_busy: start=1 seen with busy=1");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cnt;
        logic stall_ok;
        logic early_ok;
        step();
        bus.D_is_md = v.dmd;
        bus.MDUOp   = v.op;
        bus.rs_val  = v.rs;
        bus.rt_val  = v.rt;
        bus.start   = 1'b1;
        #1;
        stall_ok = (bus.stall === v.dmd);
        step();
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;
        #1;
        cnt = 0;
        early_ok = 1'b1;
        while (bus.busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (bus.stall !== v.dmd) stall_ok = 1'b0;
            if (bus.HI !== hi_m || bus.LO !== lo_m) early_ok = 1'b0;
            step();
        end
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        check($sformatf("v%0d busy_cycles", idx), cnt, v.n);
        check($sformatf("v%0d stall", idx), {31'b0, stall_ok}, 32'd1);
        check($sformatf("v%0d no_early_commit", idx), {31'b0, early_ok}, 32'd1);
        check($sformatf("v%0d HI", idx), bus.HI, v.hi);
        check($sformatf("v%0d LO", idx), bus.LO, v.lo);
        hi_m = v.hi;
        lo_m = v.lo;
        bus.D_is_md = 1'b0;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        step();
        bus.MDUOp  = op;
        bus.rs_val = val;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;
        #1;
        check("mt busy", {31'b0, bus.busy}, 32'd0);
        if (op == MDU_MTHI) hi_m = val;
        else lo_m = val;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        reset       = 1'b1;
        bus.MDUOp   = MDU_NONE;
        bus.start   = 1'b0;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        bus.D_is_md = 1'b0;

        tbl[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,
                   32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1};
        tbl[1] = '{MDU_DIVU,  32'd7, 32'd2,
                   32'd1, 32'd3, 10, 1'b0};
        tbl[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0};
        tbl[3] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 5, 1'b0};
        tbl[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF,
                   32'h00000000, 32'h80000000, 10, 1'b1};
        tbl[5] = '{MDU_DIV,   32'd7, 32'hFFFFFFFE,
                   32'h00000001, 32'hFFFFFFFD, 10, 1'b0};
        tbl[6] = '{MDU_MULT,  32'h80000000, 32'h80000000,
                   32'h40000000, 32'h00000000, 5, 1'b0};
        tbl[7] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010,
                   32'h0000000F, 32'h0FFFFFFF, 10, 1'b0};

        step();
        step();
        reset = 1'b0;
        bus.D_is_md = 1'b1;
        #1;
        check("rst busy", {31'b0, bus.busy}, 32'd0);
        check("rst stall", {31'b0, bus.stall}, 32'd0);
        check("rst HI", bus.HI, 32'd0);
        check("rst LO", bus.LO, 32'd0);
        bus.MDUOp = MDU_MFHI;
        bus.start = 1'b1;
        #1;
        check("rst MDU_out", bus.MDU_out, 32'd0);
        bus.start   = 1'b0;
        bus.MDUOp   = MDU_NONE;
        bus.D_is_md = 1'b0;

        for (int i = 0; i < 8; i++) run_op(tbl[i], i);

        // divide by zero keeps the preloaded HI/LO
        mt(MDU_MTHI, 32'h11);
        mt(MDU_MTLO, 32'h22);
        run_op('{MDU_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0}, 8);

        mt(MDU_MTLO, 32'hDEADBEEF);
        bus.MDUOp = MDU_MFLO;
        bus.start = 1'b1;
        #1;
        check("mflo MDU_out", bus.MDU_out, 32'hDEADBEEF);
        check("mflo busy", {31'b0, bus.busy}, 32'd0);
        bus.MDUOp = MDU_MFHI;
        #1;
        check("mfhi MDU_out", bus.MDU_out, 32'h11);
        step();
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;

        step();
        bus.MDUOp  = MDU_DIV;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort busy", {31'b0, bus.busy}, 32'd0);
        check("abort HI", bus.HI, 32'd0);
        check("abort LO", bus.LO, 32'd0);
        for (int i = 0; i < 15; i++) step();
        check("abort late busy", {31'b0, bus.busy}, 32'd0);
        check("abort late HI", bus.HI, 32'd0);
        check("abort late LO", bus.LO, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
